// File: rtl/ternary_pc_pkg.sv
// rtl/ternary_pc_pkg.sv - shared types, ternary codes and approximation mask helper
package ternary_pc_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [1:0] TERN_POS  = 2'b01;
    localparam logic [1:0] TERN_NEG  = 2'b11;
    localparam logic [1:0] TERN_ZERO = 2'b00;

    // A set bit means "counted"; the top bit of every chunk is dropped in approximate mode.
    function automatic logic [63:0] approx_mask(input int n, input int chunk);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < n && i < 64; i++) begin
            m[i] = ((i % chunk) != (chunk - 1));
        end
        return m;
    endfunction

endpackage

// File: rtl/popcount_masked_core.sv
// rtl/popcount_masked_core.sv - combinational popcount of the bits enabled by a mask
module popcount_masked_core
    import ternary_pc_pkg::*;
#(
    parameter int N  = 6,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  i_bits,
    input  logic [N-1:0]  i_mask,
    output logic [CW-1:0] o_count
);

    // Plain ripple sum; N is small so the tree shape is left to synthesis.
    always_comb begin
        o_count = '0;
        for (int i = 0; i < N; i++) begin
            o_count = o_count + CW'(i_bits[i] & i_mask[i]);
        end
    end

endmodule

// File: rtl/ternary_popcount_accum.sv
// rtl/ternary_popcount_accum.sv - streaming pos/neg popcount accumulator with ternary threshold output
module ternary_popcount_accum
    import ternary_pc_pkg::*;
#(
    parameter int N     = 6,
    parameter int CHUNK = 3,
    parameter int ACC_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0]            in_pos,
    input  logic [N-1:0]            in_neg,
    input  logic                    in_last,
    input  logic                    approx_en,
    input  logic signed [ACC_W-1:0] thr_hi,
    input  logic signed [ACC_W-1:0] thr_lo,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic [1:0]              out_tern,
    output logic                    out_sat
);

    localparam int             CW          = $clog2(N + 1);
    localparam logic [63:0]    MASK64      = approx_mask(N, CHUNK);
    localparam logic [N-1:0]   MASK_APPROX = MASK64[N-1:0];

    state_t                    r_state;
    logic                      r_in_ready;
    logic                      r_first_pending;
    logic                      r_approx_hold;

    logic                      r_s1_valid;
    logic                      r_s1_last;
    logic                      r_s1_first;
    logic [CW-1:0]             r_s1_pos;
    logic [CW-1:0]             r_s1_neg;

    logic [ACC_W-1:0]          r_acc;
    logic                      r_sat;
    logic                      r_s2_last;

    logic signed [ACC_W-1:0]   r_thr_hi;
    logic signed [ACC_W-1:0]   r_thr_lo;
    logic [ACC_W-1:0]          r_out_sum;
    logic [1:0]                r_out_tern;
    logic                      r_out_sat;
    logic                      r_out_valid;

    logic                      w_accept;
    logic                      w_approx;
    logic [N-1:0]              w_mask;
    logic [CW-1:0]             w_pc_pos;
    logic [CW-1:0]             w_pc_neg;
    logic [ACC_W-1:0]          w_base;
    logic [ACC_W:0]            w_sum_wide;
    logic                      w_clamp;
    logic [ACC_W-1:0]          w_acc_next;
    logic                      w_sat_next;
    logic [1:0]                w_tern;

    assign w_accept  = in_valid && r_in_ready;
    // Mode is latched on the first beat so a frame is never mixed exact/approximate.
    assign w_approx  = r_first_pending ? approx_en : r_approx_hold;
    assign w_mask    = w_approx ? MASK_APPROX : {N{1'b1}};

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_tern  = r_out_tern;
    assign out_sat   = r_out_sat;

    popcount_masked_core #(.N(N), .CW(CW)) u_pc_pos (
        .i_bits  (in_pos),
        .i_mask  (w_mask),
        .o_count (w_pc_pos)
    );

    popcount_masked_core #(.N(N), .CW(CW)) u_pc_neg (
        .i_bits  (in_neg),
        .i_mask  (w_mask),
        .o_count (w_pc_neg)
    );

    // One guard bit covers any single-beat step; a mismatch of the top two bits means overflow.
    always_comb begin
        w_base     = r_s1_first ? '0 : r_acc;
        w_sum_wide = {w_base[ACC_W-1], w_base}
                   + {{(ACC_W + 1 - CW){1'b0}}, r_s1_pos}
                   - {{(ACC_W + 1 - CW){1'b0}}, r_s1_neg};
        w_clamp    = w_sum_wide[ACC_W] ^ w_sum_wide[ACC_W-1];
        w_acc_next = w_sum_wide[ACC_W-1:0];
        if (w_clamp) begin
            w_acc_next = w_sum_wide[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}}
                                           : {1'b0, {(ACC_W - 1){1'b1}}};
        end
        w_sat_next = (r_s1_first ? 1'b0 : r_sat) | w_clamp;
    end

    // Threshold compare on the settled frame sum; +1 wins when the thresholds cross.
    always_comb begin
        w_tern = TERN_ZERO;
        if ($signed(r_acc) > r_thr_hi) begin
            w_tern = TERN_POS;
        end else if ($signed(r_acc) < r_thr_lo) begin
            w_tern = TERN_NEG;
        end
    end

    // Frame control: accept beats in ACCUM, drain for one cycle, then hold the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ACCUM;
            r_in_ready      <= 1'b1;
            r_first_pending <= 1'b1;
            r_approx_hold   <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        r_first_pending <= 1'b0;
                        r_approx_hold   <= w_approx;
                        if (in_last) begin
                            r_state    <= FLUSH;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    r_state <= HOLD;
                end
                HOLD: begin
                    if (r_out_valid && out_ready) begin
                        r_state         <= ACCUM;
                        r_in_ready      <= 1'b1;
                        r_first_pending <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ACCUM;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    // S1: capture per-beat counts and frame markers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_pos   <= '0;
            r_s1_neg   <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_last  <= in_last;
                r_s1_first <= r_first_pending;
                r_s1_pos   <= w_pc_pos;
                r_s1_neg   <= w_pc_neg;
            end
        end
    end

    // S2: saturating accumulate with sticky saturation flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_sat     <= 1'b0;
            r_s2_last <= 1'b0;
        end else begin
            r_s2_last <= r_s1_valid && r_s1_last;
            if (r_s1_valid) begin
                r_acc <= w_acc_next;
                r_sat <= w_sat_next;
            end
        end
    end

    // Result registers: thresholds captured in FLUSH, result loaded once the last beat has retired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_thr_hi    <= '0;
            r_thr_lo    <= '0;
            r_out_sum   <= '0;
            r_out_tern  <= TERN_ZERO;
            r_out_sat   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (r_state == FLUSH) begin
                r_thr_hi <= thr_hi;
                r_thr_lo <= thr_lo;
            end
            if (r_s2_last) begin
                r_out_sum   <= r_acc;
                r_out_tern  <= w_tern;
                r_out_sat   <= r_sat;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ternary_popcount_accum.sv
// tb/tb_ternary_popcount_accum.sv - directed self-checking bench for ternary_popcount_accum
module tb_ternary_popcount_accum;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [5:0]        in_pos = '0;
    logic [5:0]        in_neg = '0;
    logic              in_last = 1'b0;
    logic              approx_en = 1'b0;
    logic signed [7:0] thr_hi = 8'sd2;
    logic signed [7:0] thr_lo = -8'sd2;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic signed [7:0] out_sum;
    logic [1:0]        out_tern;
    logic              out_sat;

    int n_assert = 0;
    int n_fail   = 0;

    ternary_popcount_accum #(.N(6), .CHUNK(3), .ACC_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pos    (in_pos),
        .in_neg    (in_neg),
        .in_last   (in_last),
        .approx_en (approx_en),
        .thr_hi    (thr_hi),
        .thr_lo    (thr_lo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_tern  (out_tern),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_sum(input string tag, input logic signed [7:0] obs, input logic signed [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [5:0] p, input logic [5:0] n, input logic l, input logic a);
        in_valid  = 1'b1;
        in_pos    = p;
        in_neg    = n;
        in_last   = l;
        approx_en = a;
        tick();
        in_valid  = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int cyc;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk(tag, cyc, 2);
    endtask

    task automatic check_result(input string tag, input logic signed [7:0] s,
                                input logic [1:0] t, input logic sat);
        chk_sum({tag, "_sum"}, out_sum, s);
        chk({tag, "_tern"}, 32'(out_tern), 32'(t));
        chk({tag, "_sat"}, 32'(out_sat), 32'(sat));
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        check_result("rst", 8'sd0, 2'b00, 1'b0);

        // Exact single beat: 6 - 2 = 4 > thr_hi
        beat(6'b111111, 6'b000011, 1'b1, 1'b0);
        wait_out("t1_latency");
        check_result("t1", 8'sd4, 2'b01, 1'b0);
        chk("t1_in_ready_hold", 32'(in_ready), 0);
        consume();
        chk("t1_valid_drop", 32'(out_valid), 0);
        chk("t1_in_ready_back", 32'(in_ready), 1);

        // Approx single beat: bits 2,5 ignored -> 4 - 2 = 2, not above thr_hi
        beat(6'b111111, 6'b000011, 1'b1, 1'b1);
        wait_out("t2_latency");
        check_result("t2", 8'sd2, 2'b00, 1'b0);
        consume();

        // Approx mode held for the frame even though approx_en drops on beat 2: 4 + 4
        beat(6'b111111, 6'b000000, 1'b0, 1'b1);
        beat(6'b111111, 6'b000000, 1'b1, 1'b0);
        wait_out("t2b_latency");
        check_result("t2b", 8'sd8, 2'b01, 1'b0);
        consume();

        // Saturation: 30 x 6 = 180 clamps to 127
        for (int i = 0; i < 30; i++) begin
            beat(6'b111111, 6'b000000, (i == 29), 1'b0);
        end
        wait_out("t3_latency");
        check_result("t3", 8'sd127, 2'b01, 1'b1);
        consume();
        beat(6'b000000, 6'b000000, 1'b1, 1'b0);
        wait_out("t3b_latency");
        check_result("t3b", 8'sd0, 2'b00, 1'b0);
        consume();

        // Negative frame: 3 x -6 = -18 < thr_lo
        thr_lo = -8'sd10;
        for (int i = 0; i < 3; i++) begin
            beat(6'b000000, 6'b111111, (i == 2), 1'b0);
        end
        wait_out("t4_latency");
        check_result("t4", -8'sd18, 2'b11, 1'b0);
        consume();
        thr_lo = -8'sd2;

        // Backpressure with a beat offered during HOLD that must be ignored
        beat(6'b000001, 6'b000000, 1'b1, 1'b0);
        wait_out("t5_latency");
        in_valid = 1'b1;
        in_pos   = 6'b111111;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_hold_in_ready", 32'(in_ready), 0);
            chk("t5_hold_valid", 32'(out_valid), 1);
            chk_sum("t5_hold_sum", out_sum, 8'sd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        consume();
        chk("t5_valid_drop", 32'(out_valid), 0);
        chk("t5_in_ready_back", 32'(in_ready), 1);
        chk_sum("t5_sum_retained", out_sum, 8'sd1);
        beat(6'b000111, 6'b000000, 1'b1, 1'b0);
        wait_out("t5b_latency");
        check_result("t5b", 8'sd3, 2'b01, 1'b0);
        consume();

        // Reset mid-frame discards the partial frame and clears the held result
        for (int i = 0; i < 3; i++) begin
            beat(6'b000111, 6'b000000, 1'b0, 1'b0);
        end
        rst = 1'b1;
        #2;
        chk("t6_rst_valid", 32'(out_valid), 0);
        chk("t6_rst_in_ready", 32'(in_ready), 1);
        check_result("t6_rst", 8'sd0, 2'b00, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        beat(6'b000001, 6'b000000, 1'b1, 1'b0);
        wait_out("t6_latency");
        check_result("t6", 8'sd1, 2'b00, 1'b0);
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
